// File: rtl/ddr_dly_tap_ctrl.sv
// Delay-line tap sequencer for one IOD lane: turns a target-tap request into LOAD/MOVE/DIRECTION pulses.
// Optional macro DDR_DLY_TAP_CTRL_RELOAD_ON_ERR_EN: an out-of-range step re-centres the line to LOAD_TAP.
module ddr_dly_tap_ctrl #(
   parameter int TAP_W    = 8,
   parameter int TAP_MAX  = 127,
   parameter int LOAD_TAP = 1,
   parameter int MOVE_GAP = 3
) (
   input  logic             FAB_CLK,
   input  logic             ARST,
   input  logic             REQ_VALID,
   input  logic [TAP_W-1:0] REQ_TAP,
   input  logic             REQ_LOAD,
   output logic             REQ_READY,
   output logic             DONE,
   output logic             ERR,
   output logic [TAP_W-1:0] CUR_TAP,
   output logic             BUSY,
   output logic             DELAY_LINE_LOAD,
   output logic             DELAY_LINE_MOVE,
   output logic             DELAY_LINE_DIRECTION,
   input  logic             DELAY_LINE_OUT_OF_RANGE
);

   localparam logic [TAP_W-1:0] TAP_MAX_V  = TAP_W'(TAP_MAX);
   localparam logic [TAP_W-1:0] LOAD_TAP_V = TAP_W'(LOAD_TAP);
   localparam logic [3:0]       GAP_LAST   = 4'(MOVE_GAP - 1);

   typedef enum logic [2:0] {IDLE, CHK, LOAD, MOVE, GAP, FIN} state_t;

   state_t           state, state_nxt;
   logic [TAP_W-1:0] tgt;
   logic [TAP_W-1:0] tap_step;
   logic             load_req;
   logic             after_load;
   logic [3:0]       gap_cnt;
   logic             gap_last;
   logic             accept;
   logic             err_set;
   logic             dir_set;
   logic             step_ok;

   assign accept   = (state == IDLE) && REQ_VALID;
   assign gap_last = (gap_cnt == 4'd0);
   assign tap_step = DELAY_LINE_DIRECTION ? CUR_TAP + 1'b1 : CUR_TAP - 1'b1;
   assign step_ok  = (state == GAP) && gap_last && !after_load && !DELAY_LINE_OUT_OF_RANGE;

   always_ff @(posedge FAB_CLK or posedge ARST) begin
      if (ARST) state <= IDLE;
      else      state <= state_nxt;
   end

   // The re-check after a successful step is folded into the last gap cycle,
   // so each step costs exactly one move cycle plus MOVE_GAP settle cycles.
   always_comb begin
      state_nxt       = state;
      err_set         = 1'b0;
      dir_set         = 1'b0;
      REQ_READY       = 1'b0;
      BUSY            = 1'b1;
      DONE            = 1'b0;
      DELAY_LINE_LOAD = 1'b0;
      DELAY_LINE_MOVE = 1'b0;
      case (state)
         IDLE: begin
            REQ_READY = 1'b1;
            BUSY      = 1'b0;
            if (REQ_VALID) state_nxt = CHK;
         end
         CHK: begin
            if (load_req) state_nxt = LOAD;
            else if (tgt > TAP_MAX_V) begin
               err_set   = 1'b1;
               state_nxt = FIN;
            end else if (tgt == CUR_TAP) state_nxt = FIN;
            else begin
               dir_set   = 1'b1;
               state_nxt = MOVE;
            end
         end
         LOAD: begin
            DELAY_LINE_LOAD = 1'b1;
            state_nxt       = GAP;
         end
         MOVE: begin
            DELAY_LINE_MOVE = 1'b1;
            state_nxt       = GAP;
         end
         GAP: begin
            if (gap_last) begin
               if (after_load) state_nxt = FIN;
               else if (DELAY_LINE_OUT_OF_RANGE) begin
                  err_set = 1'b1;
`ifdef DDR_DLY_TAP_CTRL_RELOAD_ON_ERR_EN
                  state_nxt = LOAD;
`else
                  state_nxt = FIN;
`endif
               end else if (tap_step == tgt) state_nxt = FIN;
               else state_nxt = MOVE;
            end
         end
         FIN: begin
            DONE      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge FAB_CLK or posedge ARST) begin
      if (ARST) begin
         ERR                  <= 1'b0;
         CUR_TAP              <= LOAD_TAP_V;
         DELAY_LINE_DIRECTION <= 1'b0;
         gap_cnt              <= 4'd0;
         after_load           <= 1'b0;
      end else begin
         if (accept)       ERR <= 1'b0;
         else if (err_set) ERR <= 1'b1;
         if (dir_set) DELAY_LINE_DIRECTION <= (tgt > CUR_TAP);
         if (state == LOAD) CUR_TAP <= LOAD_TAP_V;
         else if (step_ok)  CUR_TAP <= tap_step;
         if (state == LOAD || state == MOVE) begin
            gap_cnt    <= GAP_LAST;
            after_load <= (state == LOAD);
         end else if (state == GAP && !gap_last) begin
            gap_cnt <= gap_cnt - 4'd1;
         end
      end
   end

   // Request fields are only consulted after an accept, so they carry no reset.
   always_ff @(posedge FAB_CLK) begin
      if (accept) begin
         tgt      <= REQ_TAP;
         load_req <= REQ_LOAD;
      end
   end

endmodule

// File: tb/tb_ddr_dly_tap_ctrl.sv
// Scoreboard bench for ddr_dly_tap_ctrl: directed scenarios plus randomized requests vs an arithmetic model.
module tb_ddr_dly_tap_ctrl;

   localparam int TAP_W    = 8;
   localparam int TAP_MAX  = 127;
   localparam int LOAD_TAP = 1;
   localparam int MOVE_GAP = 3;
   localparam int STEP     = 1 + MOVE_GAP;
   localparam int LIMIT    = 1000;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             req_valid = 1'b0;
   logic [TAP_W-1:0] req_tap = '0;
   logic             req_load = 1'b0;
   logic             req_ready, done, err, busy;
   logic [TAP_W-1:0] cur_tap;
   logic             dl_load, dl_move, dl_dir;
   logic             dl_oor = 1'b0;

   always #5 clk = ~clk;

   ddr_dly_tap_ctrl #(
      .TAP_W(TAP_W), .TAP_MAX(TAP_MAX), .LOAD_TAP(LOAD_TAP), .MOVE_GAP(MOVE_GAP)
   ) dut (
      .FAB_CLK(clk), .ARST(rst), .REQ_VALID(req_valid), .REQ_TAP(req_tap),
      .REQ_LOAD(req_load), .REQ_READY(req_ready), .DONE(done), .ERR(err),
      .CUR_TAP(cur_tap), .BUSY(busy), .DELAY_LINE_LOAD(dl_load),
      .DELAY_LINE_MOVE(dl_move), .DELAY_LINE_DIRECTION(dl_dir),
      .DELAY_LINE_OUT_OF_RANGE(dl_oor)
   );

   typedef struct {
      int lat;
      int err;
      int tap;
      int moves;
      int loads;
      int dir;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   model_tap = LOAD_TAP;
   int   last_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Expected outcome from the request rules: distance, failing step and load are plain arithmetic.
   task automatic model(input int cur, input int tgt, input int ld, input int fk,
                        output exp_t e, output int nt);
      int n;
      e.moves = 0; e.loads = 0; e.err = 0; e.dir = 0; nt = cur;
      if (ld != 0) begin
         e.loads = 1; nt = LOAD_TAP; e.lat = 3 + MOVE_GAP;
      end else if (tgt > TAP_MAX) begin
         e.err = 1; e.lat = 2;
      end else begin
         n     = (tgt > cur) ? tgt - cur : cur - tgt;
         e.dir = (tgt > cur) ? 1 : 0;
         if (fk >= 1 && fk <= n) begin
            e.moves = fk;
            e.err   = 1;
            nt      = (tgt > cur) ? cur + (fk - 1) : cur - (fk - 1);
            e.lat   = 2 + fk * STEP;
`ifdef DDR_DLY_TAP_CTRL_RELOAD_ON_ERR_EN
            e.loads = 1;
            nt      = LOAD_TAP;
            e.lat   = e.lat + STEP;
`endif
         end else begin
            e.moves = n;
            nt      = tgt;
            e.lat   = 2 + n * STEP;
         end
      end
      e.tap = nt;
   endtask

   // Monitor: counts pulses and pops one expectation per DONE.
   initial begin
      int   mv, ld, ovl;
      exp_t e;
      mv = 0; ld = 0; ovl = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mv = 0; ld = 0; ovl = 0;
         end else begin
            if (dl_move) begin
               mv++;
               if (sbq.size() > 0) chk("move_direction", int'(dl_dir), sbq[0].dir);
            end
            if (dl_load) ld++;
            if (dl_load && dl_move) ovl++;
            if (done) begin
               chk("done_has_pending_req", int'(sbq.size() > 0), 1);
               if (sbq.size() > 0) begin
                  e = sbq.pop_front();
                  chk("done_latency", cyc - acc_cyc + 1, e.lat);
                  chk("done_err", int'(err), e.err);
                  chk("done_cur_tap", int'(cur_tap), e.tap);
                  chk("move_pulses", mv, e.moves);
                  chk("load_pulses", ld, e.loads);
                  chk("load_move_overlap", ovl, 0);
               end
               mv = 0; ld = 0; ovl = 0;
            end
         end
      end
   end

   task automatic do_req(input int tgt, input int ld, input int fk, input int junk);
      exp_t e;
      int   nt, mv;
      bit   seen;
      @(negedge clk);
      for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
      chk("ready_before_req", int'(req_ready), 1);
      chk("err_held_idle", int'(err), last_err);
      model(model_tap, tgt, ld, fk, e, nt);
      sbq.push_back(e);
      req_valid = 1'b1;
      req_tap   = TAP_W'(tgt);
      req_load  = ld[0];
      @(posedge clk);
      #1;
      acc_cyc   = cyc;
      req_valid = 1'b0;
      chk("accept_busy", int'(busy), 1);
      chk("accept_ready_low", int'(req_ready), 0);
      chk("accept_err_cleared", int'(err), 0);
      mv = 0; seen = 1'b0;
      for (int i = 0; i < LIMIT && !seen; i++) begin
         @(negedge clk);
         if (junk != 0) begin
            req_valid = 1'($urandom_range(0, 1));
            req_tap   = TAP_W'($urandom);
            req_load  = 1'($urandom_range(0, 1));
         end
         if (dl_move) begin
            mv++;
            if (mv == fk) dl_oor = 1'b1;
         end
         if (done) seen = 1'b1;
      end
      chk("done_seen", int'(done), 1);
      req_valid = 1'b0;
      req_load  = 1'b0;
      dl_oor    = 1'b0;
      model_tap = nt;
      last_err  = e.err;
   endtask

   initial begin
      int tgt, ld, fk, n, quiet;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ready", int'(req_ready), 1);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_dl_load", int'(dl_load), 0);
      chk("rst_dl_move", int'(dl_move), 0);
      chk("rst_dl_dir", int'(dl_dir), 0);
      chk("rst_cur_tap", int'(cur_tap), LOAD_TAP);
      #2 rst = 1'b0;

      do_req(5, 0, 0, 0);
      do_req(2, 0, 0, 0);
      do_req(2, 0, 0, 1);
      do_req(200, 0, 0, 0);
      do_req(1, 0, 0, 0);
      do_req(10, 0, 3, 0);
      do_req(99, 1, 0, 1);

      // Abort a 6-step request from tap 1 while it sits in a gap.
      @(negedge clk);
      chk("abort_start_tap", int'(cur_tap), 1);
      req_valid = 1'b1; req_tap = 8'd7; req_load = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 100 && n < 2; i++) begin
         @(negedge clk);
         if (dl_move) n++;
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_ready", int'(req_ready), 1);
      chk("abort_done", int'(done), 0);
      chk("abort_err", int'(err), 0);
      chk("abort_dl_move", int'(dl_move), 0);
      chk("abort_dl_load", int'(dl_load), 0);
      chk("abort_dl_dir", int'(dl_dir), 0);
      chk("abort_cur_tap", int'(cur_tap), LOAD_TAP);
      @(negedge clk);
      #2 rst = 1'b0;
      model_tap = LOAD_TAP;
      last_err  = 0;
      @(negedge clk);
      chk("ready_after_arst", int'(req_ready), 1);
      quiet = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done || busy) quiet++;
      end
      chk("no_done_after_abort", quiet, 0);

      for (int k = 0; k < 40; k++) begin
         ld  = ($urandom_range(0, 9) == 0) ? 1 : 0;
         tgt = ($urandom_range(0, 6) == 0) ? int'($urandom_range(128, 255))
                                            : int'($urandom_range(0, TAP_MAX));
         n   = (tgt > model_tap) ? tgt - model_tap : model_tap - tgt;
         fk  = (n > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, n)) : 0;
         do_req(tgt, ld, fk, int'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

endmodule
